alu_result_collector: RTL and testbench



---
 rtl/alu_collector_pkg.sv | 31 +++
 rtl/collector_sync_fifo.sv | 79 +++++++
 rtl/alu_result_collector.sv | 140 ++++++++++++++
 tb/tb_alu_result_collector.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_collector_pkg.sv
// -----------------------------------------------------------------------------
// alu_collector_pkg
// Shared definitions for the ALU result collector:
//   - FSM state encoding (IDLE / CAPTURE / DRAIN)
//   - default width constants
//   - bit offsets of the fields inside rd_data = {opcode, carry, result}
// Optional feature macro used by the collector: ALU_RESULT_COLLECTOR_PARITY_EN
// -----------------------------------------------------------------------------
package alu_collector_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Field offsets of rd_data for the default widths.
  localparam int RD_RESULT_LSB = 0;
  localparam int RD_CARRY_BIT  = DEFAULT_DATA_WIDTH;
  localparam int RD_OPCODE_LSB = DEFAULT_DATA_WIDTH + 1;
  localparam int RD_WIDTH      = DEFAULT_ADDR_WIDTH + 1 + DEFAULT_DATA_WIDTH;

  // Width of a packed {opcode, carry, result} word for arbitrary widths.
  function automatic int rd_word_width(input int data_width, input int addr_width);
    return addr_width + 1 + data_width;
  endfunction

endpackage

// File: rtl/collector_sync_fifo.sv
// -----------------------------------------------------------------------------
// collector_sync_fifo
// Show-ahead synchronous FIFO, depth 2^ADDR_WIDTH. The head word is presented
// on pop_data whenever the FIFO is non-empty (zero when empty).
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   push, push_data    write request and word
//   pop                read request (ignored when empty)
//   pop_data           head word
//   count              occupancy 0..2^ADDR_WIDTH
//   full, empty        status
//   drop               a push was rejected this cycle (full, no pop)
// -----------------------------------------------------------------------------
module collector_sync_fifo #(
  parameter int WIDTH      = 13,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly ADDR_WIDTH wide, so they wrap modulo the depth.
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
// Captures {opcode, carry, result} samples from an ALU during a session opened
// by CS, through a one-stage pipeline into a show-ahead FIFO, and lets a
// consumer read them back with a valid/ready handshake in any state.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   CS                       session select
//   capture_en               qualifies the current sample
//   opcode_in, result_in,
//   carry_in                 ALU operands/results to record
//   rd_ready                 consumer accepts rd_data
//   rd_valid, rd_data        head word {opcode, carry, result}
//   count, full, empty       FIFO status
//   overflow                 sticky: a capture was dropped
//   busy                     FSM not in IDLE
//   rd_parity_err            (only with ALU_RESULT_COLLECTOR_PARITY_EN) head
//                            word fails its even-parity check
// -----------------------------------------------------------------------------
module alu_result_collector
  import alu_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           CS,
  input  logic                           capture_en,
  input  logic [ADDR_WIDTH-1:0]          opcode_in,
  input  logic [DATA_WIDTH-1:0]          result_in,
  input  logic                           carry_in,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [ADDR_WIDTH+DATA_WIDTH:0] rd_data,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           full,
  output logic                           empty,
  output logic                           overflow,
  output logic                           busy
`ifdef ALU_RESULT_COLLECTOR_PARITY_EN
  ,
  output logic                           rd_parity_err
`endif
);

  localparam int WORD_W = ADDR_WIDTH + 1 + DATA_WIDTH;
`ifdef ALU_RESULT_COLLECTOR_PARITY_EN
  localparam int FIFO_W = WORD_W + 1;
`else
  localparam int FIFO_W = WORD_W;
`endif

  state_e              state_q, state_d;
  logic                busy_q;
  logic                pipe_valid_q, pipe_valid_d;
  logic [WORD_W-1:0]   pipe_data_q, pipe_data_d;
  logic                overflow_q, overflow_d;
  logic                capture_fire;
  logic [FIFO_W-1:0]   fifo_wdata, fifo_rdata;
  logic                fifo_drop, fifo_empty;

  assign capture_fire = (state_q == CAPTURE) && CS && capture_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CS) state_d = CAPTURE;
      CAPTURE: if (!CS) state_d = DRAIN;
      DRAIN: begin
        if (CS)                                state_d = CAPTURE;
        else if (fifo_empty && !pipe_valid_q)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_valid_d = capture_fire;
    pipe_data_d  = capture_fire ? {opcode_in, carry_in, result_in} : pipe_data_q;
    overflow_d   = overflow_q;
    // A new session clears the flag; a drop on the same edge still wins.
    if ((state_q == IDLE) && CS) overflow_d = 1'b0;
    if (fifo_drop)               overflow_d = 1'b1;
  end

  // FSM with registered busy output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q <= 1'b0;
      pipe_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q  <= pipe_data_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef ALU_RESULT_COLLECTOR_PARITY_EN
  // Stored parity bit makes the whole stored word even parity.
  assign fifo_wdata    = {^pipe_data_q, pipe_data_q};
  assign rd_parity_err = !fifo_empty && (^fifo_rdata);
`else
  assign fifo_wdata = pipe_data_q;
`endif

  collector_sync_fifo #(
    .WIDTH      (FIFO_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pipe_valid_q),
    .push_data (fifo_wdata),
    .pop       (rd_ready),
    .pop_data  (fifo_rdata),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign empty    = fifo_empty;
  assign rd_valid = !fifo_empty;
  assign rd_data  = fifo_rdata[WORD_W-1:0];
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_alu_result_collector
// Scoreboard bench for alu_result_collector: expected words are queued when a
// capture is driven and compared when the DUT hands them out.
// Optional feature macro exercised when defined: ALU_RESULT_COLLECTOR_PARITY_EN
// -----------------------------------------------------------------------------
module tb_alu_result_collector;
  import alu_collector_pkg::*;

  logic        clk;
  logic        reset;
  logic        CS;
  logic        capture_en;
  logic [3:0]  opcode_in;
  logic [7:0]  result_in;
  logic        carry_in;
  logic        rd_ready;
  logic        rd_valid;
  logic [12:0] rd_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        busy;
`ifdef ALU_RESULT_COLLECTOR_PARITY_EN
  logic        rd_parity_err;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [12:0] exp_q[$];

  alu_result_collector #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .CS         (CS),
    .capture_en (capture_en),
    .opcode_in  (opcode_in),
    .result_in  (result_in),
    .carry_in   (carry_in),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .busy       (busy)
`ifdef ALU_RESULT_COLLECTOR_PARITY_EN
    ,
    .rd_parity_err (rd_parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One capture cycle; leaves capture_en high for back-to-back use.
  task automatic cap(input logic [3:0] op, input bit store);
    logic [7:0] r;
    logic       c;
    r = 8'($urandom);
    c = 1'($urandom);
    capture_en = 1'b1;
    opcode_in  = op;
    result_in  = r;
    carry_in   = c;
    if (store) exp_q.push_back({op, c, r});
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!empty && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, empty, 1);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Read-side monitor: a pop happens on the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("rdv_vs_empty", rd_valid, !empty);
      if (rd_valid && rd_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [12:0] e;
          e = exp_q.pop_front();
          $display("pop op=%h c=%b res=%h", rd_data[RD_OPCODE_LSB +: 4],
                   rd_data[RD_CARRY_BIT], rd_data[RD_RESULT_LSB +: 8]);
          check("rd_data", rd_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; CS = 1'b0; capture_en = 1'b0;
    opcode_in = '0; result_in = '0; carry_in = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: single capture, visible two edges later.
    CS = 1'b1;
    @(posedge clk); #1;
    capture_en = 1'b1; opcode_in = 4'h3; result_in = 8'hA5; carry_in = 1'b1;
    exp_q.push_back({4'h3, 1'b1, 8'hA5});
    @(posedge clk); #1;
    capture_en = 1'b0;
    check("lat_edge1_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_rd_valid", rd_valid, 1);
    check("lat_rd_data", rd_data, 13'h07A5);
    $display("latency word=%h", rd_data);
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    check("lat_popped_empty", empty, 1);

    // Reset in the middle of a session.
    for (int i = 0; i < 5; i++) cap(4'(i), 1'b1);
    capture_en = 1'b0;
    @(posedge clk); #1;
    check("mid_count_before", count, 5);
    reset = 1'b1;
    #1;
    check("mid_async_count", count, 0);
    exp_q.delete();
    CS = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_count", count, 0);
    check("mid_empty", empty, 1);
    check("mid_rd_valid", rd_valid, 0);
    check("mid_state", dut.state_q, IDLE);
    check("mid_busy", busy, 0);

    // Overflow: 17 captures, the last one dropped.
    CS = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) cap(4'(i), i < 16);
    capture_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ovf_count", count, 16);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_head_stable", rd_data, exp_q[0]);
    rd_ready = 1'b1;
    wait_empty("ovf_drain_timeout", 40);
    rd_ready = 1'b0;
    CS = 1'b0;
    wait_idle("ovf_idle_timeout", 20);

    // New session clears overflow; then push+pop while full.
    CS = 1'b1;
    @(posedge clk); #1;
    check("sim_ovf_cleared", overflow, 0);
    for (int i = 0; i < 16; i++) cap(4'(i), 1'b1);
    capture_en = 1'b0;
    @(posedge clk); #1;
    check("sim_count_full", count, 16);
    check("sim_full", full, 1);
    for (int k = 0; k < 8; k++) begin
      cap(4'(k + 8), 1'b1);
      if (k == 0) rd_ready = 1'b1;
      else        check("sim_count_hold", count, 16);
    end
    capture_en = 1'b0;
    @(posedge clk); #1;
    check("sim_count_last", count, 16);
    check("sim_no_overflow", overflow, 0);
    wait_empty("sim_drain_timeout", 40);

    // Drain and wrap-around: 20 words with rd_ready held high.
    for (int i = 0; i < 20; i++) cap(4'(15 - (i % 16)), 1'b1);
    CS = 1'b0;
    capture_en = 1'b0;
    @(posedge clk); #1;
    check("drn_state", dut.state_q, DRAIN);
    check("drn_busy", busy, 1);
    wait_idle("drn_idle_timeout", 30);
    check("drn_state_idle", dut.state_q, IDLE);
    check("drn_empty", empty, 1);
    check("drn_sb_empty", exp_q.size(), 0);
    rd_ready = 1'b0;

`ifdef ALU_RESULT_COLLECTOR_PARITY_EN
    // Parity: flip the stored parity bit of the second word.
    CS = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cap(4'(i), 1'b1);
    capture_en = 1'b0;
    @(posedge clk); #1;
    dut.u_fifo.mem_q[dut.u_fifo.rd_ptr_q + 4'd1][13] = ~dut.u_fifo.mem_q[dut.u_fifo.rd_ptr_q + 4'd1][13];
    check("par_word0", rd_parity_err, 0);
    rd_ready = 1'b1; @(posedge clk); #1; rd_ready = 1'b0;
    check("par_word1", rd_parity_err, 1);
    rd_ready = 1'b1; @(posedge clk); #1; rd_ready = 1'b0;
    check("par_word2", rd_parity_err, 0);
    rd_ready = 1'b1;
    wait_empty("par_drain_timeout", 10);
    rd_ready = 1'b0;
    CS = 1'b0;
    wait_idle("par_idle_timeout", 20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
